// File: rtl/alu_pipe.sv
// Handshaked ALU: registered single-cycle ops plus an iterative shift-add multiplier.
// Optional flag outputs (zero/neg/carry/ovf) are built only when ALU_FLAGS_EN is defined.
module alu_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Opin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             illegal
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
`endif
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = SW + 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
   typedef enum logic [3:0] {
      OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3, OP_SUB = 4'd4,
      OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_MUL = 4'd9
   } op_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n, a_reg, a_n, b_reg, b_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] result_n;
   logic             illegal_n, out_valid_n;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic [SW-1:0]    shamt;
   logic             accept, load_alu, load_mul;

   assign shamt    = B[SW-1:0];
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (Opin)
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_ADD:  alu_res = A + B;
         OP_XOR:  alu_res = A ^ B;
         OP_SUB:  alu_res = A - B;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL:  alu_res = A << shamt;
         OP_SRL:  alu_res = A >> shamt;
         OP_SRA:  alu_res = $signed(A) >>> shamt;
         default: alu_ill = 1'b1;
      endcase
   end

   // Multiplier shifts its operand copies instead of indexing B by cnt:
   // acc += A<<cnt when B[cnt] is equivalent to adding a_reg when b_reg[0].
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      a_n         = a_reg;
      b_n         = b_reg;
      cnt_n       = cnt;
      load_alu    = 1'b0;
      load_mul    = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (Opin == OP_MUL) begin
                  state_n = S_MUL;
                  acc_n   = '0;
                  cnt_n   = '0;
                  a_n     = A;
                  b_n     = B;
               end else begin
                  load_alu = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (cnt != CW'(WIDTH)) begin
               acc_n = acc + (b_reg[0] ? a_reg : '0);
               a_n   = a_reg << 1;
               b_n   = b_reg >> 1;
               cnt_n = cnt + 1'b1;
            end else if (out_valid && !out_ready) begin
               state_n = S_HOLD;
            end else begin
               load_mul = 1'b1;
               state_n  = S_IDLE;
            end
         end
         S_HOLD: begin
            if (!out_valid || out_ready) begin
               load_mul = 1'b1;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      result_n    = result;
      illegal_n   = illegal;
      out_valid_n = out_valid && !out_ready;
      if (load_alu) begin
         result_n    = alu_res;
         illegal_n   = alu_ill;
         out_valid_n = 1'b1;
      end else if (load_mul) begin
         result_n    = acc;
         illegal_n   = 1'b0;
         out_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         cnt       <= '0;
         result    <= '0;
         illegal   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         a_reg     <= a_n;
         b_reg     <= b_n;
         cnt       <= cnt_n;
         result    <= result_n;
         illegal   <= illegal_n;
         out_valid <= out_valid_n;
      end
   end

`ifdef ALU_FLAGS_EN
   logic [WIDTH:0] sum_x, diff_x;
   logic           carry_x, ovf_x;

   assign sum_x  = {1'b0, A} + {1'b0, B};
   assign diff_x = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      carry_x = 1'b0;
      ovf_x   = 1'b0;
      case (Opin)
         OP_ADD: begin
            carry_x = sum_x[WIDTH];
            ovf_x   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_x[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            carry_x = diff_x[WIDTH];
            ovf_x   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_x[WIDTH-1] != A[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero  <= 1'b0;
         neg   <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else if (load_alu) begin
         zero  <= (alu_res == '0);
         neg   <= alu_res[WIDTH-1];
         carry <= carry_x;
         ovf   <= ovf_x;
      end else if (load_mul) begin
         zero  <= (acc == '0);
         neg   <= acc[WIDTH-1];
         carry <= 1'b0;
         ovf   <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32): table of single-cycle ops plus
// hand sequences for MUL latency, back-pressure and reset mid-multiply.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B;
   logic [3:0]  Opin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        illegal;
`ifdef ALU_FLAGS_EN
   logic        zero, neg, carry, ovf;
`endif

   int n_vec = 0;
   int n_bad = 0;

   alu_pipe #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Opin(Opin),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .illegal(illegal)
`ifdef ALU_FLAGS_EN
      , .zero(zero), .neg(neg), .carry(carry), .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        ill;
   } vec_t;

   vec_t vecs[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int edges;
      logic rdy_seen;
      in_valid = 1'b1; Opin = 4'd9; A = a; B = b; out_ready = 1'b1;
      #1;
      check("mul_accept_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      A = '0; B = '0;
      edges = 0;
      rdy_seen = 1'b0;
      while (!out_valid && edges < 40) begin
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
         tick();
         edges++;
      end
      check("mul_latency", edges, 32'd33);
      check("mul_busy_ready", {31'd0, rdy_seen}, 32'd0);
      check("mul_result", result, exp);
      check("mul_illegal", {31'd0, illegal}, 32'd0);
      tick();
      check("mul_retire", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{4'd0, 32'h0000001B, 32'h0000002E, 32'h0000000A, 1'b0};
      vecs[1]  = '{4'd1, 32'h0000001B, 32'h0000002E, 32'h0000003F, 1'b0};
      vecs[2]  = '{4'd2, 32'h0000001B, 32'h0000002E, 32'h00000049, 1'b0};
      vecs[3]  = '{4'd3, 32'h0000001B, 32'h0000002E, 32'h00000035, 1'b0};
      vecs[4]  = '{4'd4, 32'h0000001B, 32'h0000002E, 32'hFFFFFFED, 1'b0};
      vecs[5]  = '{4'd5, 32'h0000001B, 32'h0000002E, 32'h00000001, 1'b0};
      vecs[6]  = '{4'd6, 32'h0000001B, 32'h0000002E, 32'h0006C000, 1'b0};
      vecs[7]  = '{4'd7, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
      vecs[8]  = '{4'd8, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
      vecs[9]  = '{4'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
      vecs[10] = '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
      vecs[11] = '{4'd5, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
      vecs[12] = '{4'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
      vecs[13] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[14] = '{4'd6, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0};

      reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; Opin = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // back-to-back single-cycle ops
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1;
         Opin = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
         check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         tick();
         check($sformatf("v%0d_result", i), result, vecs[i].exp);
         check($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
         check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("drain_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_FLAGS_EN
      in_valid = 1'b1; Opin = 4'd2; A = 32'h7FFFFFFF; B = 32'h00000001;
      tick();
      check("flag_ovf", {28'd0, zero, neg, carry, ovf}, 32'b0101);
      A = 32'hFFFFFFFF; B = 32'h00000001;
      tick();
      check("flag_carry", {28'd0, zero, neg, carry, ovf}, 32'b1010);
      Opin = 4'd4; A = 32'h00000005; B = 32'h00000003;
      tick();
      check("flag_sub", {28'd0, zero, neg, carry, ovf}, 32'b0010);
      in_valid = 1'b0;
      tick();
`endif

      run_mul(32'h0000001B, 32'h0000002E, 32'h000004DA);
      run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run_mul(32'h00010000, 32'h00010000, 32'h00000000);

      // back-pressure: ADD result must hold while SUB waits at the input
      out_ready = 1'b0;
      in_valid = 1'b1; Opin = 4'd2; A = 32'h1B; B = 32'h2E;
      tick();
      Opin = 4'd4;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp%0d_result", k), result, 32'h00000049);
         check($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("bp_new_result", result, 32'hFFFFFFED);
      check("bp_new_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("bp_drain", {31'd0, out_valid}, 32'd0);

      // reset in the middle of a multiply
      in_valid = 1'b1; Opin = 4'd9; A = 32'h1B; B = 32'h2E;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_result", result, 32'd0);
      begin
         logic seen;
         seen = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
         end
         check("midrst_no_result", {31'd0, seen}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
